// File: rtl/operands_buffer.sv
// Ping-pong operand store: the shadow bank is loaded with strobed row writes while
// the active bank serves registered reads; a swap handshake exchanges the banks.
module operands_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            wr_en_i,
  input  logic [ADDR_WIDTH-1:0]           wr_addr_i,
  input  logic [BUS_WIDTH-1:0]            wr_data_i,
  input  logic [BUS_WIDTH/DATA_WIDTH-1:0] wr_strb_i,
  output logic                            wr_err_o,
  input  logic                            clear_i,
  input  logic                            swap_i,
  output logic                            swap_pend_o,
  output logic                            swap_done_o,
  output logic                            active_bank_o,
  output logic                            shadow_full_o,
  input  logic                            rd_en_i,
  input  logic [ADDR_WIDTH-1:0]           rd_addr_i,
  output logic [BUS_WIDTH-1:0]            rd_data_o,
  output logic                            rd_valid_o
);

  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int IDX_W   = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;

  typedef enum logic {S_IDLE, S_PEND} state_t;

  logic [BUS_WIDTH-1:0] r_mem  [2][MAX_DIM];
  logic [MAX_DIM-1:0]   r_mask [2];
  logic                 r_active;
  state_t               r_state;
  logic                 r_swap_done;
  logic                 r_wr_err;
  logic                 r_rd_valid;
  logic [BUS_WIDTH-1:0] r_rd_data;

  logic             w_shadow;
  logic             w_full;
  logic             w_wr_inrange;
  logic             w_rd_inrange;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_rd_idx;
  logic             w_wr_ok;
  logic             w_swap;
  logic             w_new_shadow;

  assign w_shadow     = ~r_active;
  assign w_full       = &r_mask[w_shadow];
  assign w_wr_inrange = wr_addr_i < ADDR_WIDTH'(MAX_DIM);
  assign w_rd_inrange = rd_addr_i < ADDR_WIDTH'(MAX_DIM);
  assign w_wr_idx     = wr_addr_i[IDX_W-1:0];
  assign w_rd_idx     = rd_addr_i[IDX_W-1:0];
  // A clear in the same cycle wins over any write.
  assign w_wr_ok      = wr_en_i & w_wr_inrange & ~clear_i;
  assign w_swap       = w_full & (((r_state == S_IDLE) & swap_i) | (r_state == S_PEND));
  // Clear targets the bank that is the shadow after this edge's swap, if any.
  assign w_new_shadow = w_swap ? r_active : w_shadow;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_active    <= 1'b0;
      r_swap_done <= 1'b0;
      r_wr_err    <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_wr_err    <= wr_en_i & ~w_wr_inrange & ~clear_i;
      r_swap_done <= w_swap;
      if (w_swap) r_active <= ~r_active;
      case (r_state)
        S_IDLE: if (swap_i && !w_full) r_state <= S_PEND;
        S_PEND: if (w_full) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      r_rd_valid <= rd_en_i;
      if (rd_en_i) r_rd_data <= w_rd_inrange ? r_mem[r_active][w_rd_idx] : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int b = 0; b < 2; b++) begin
        r_mask[b] <= '0;
        for (int r = 0; r < MAX_DIM; r++) r_mem[b][r] <= '0;
      end
    end else begin
      if (w_wr_ok) begin
        for (int k = 0; k < MAX_DIM; k++)
          if (wr_strb_i[k])
            r_mem[w_shadow][w_wr_idx][k*DATA_WIDTH +: DATA_WIDTH] <= wr_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        if (|wr_strb_i) r_mask[w_shadow][w_wr_idx] <= 1'b1;
      end
      // Load tracking restarts for both banks on a swap.
      if (w_swap) begin
        r_mask[0] <= '0;
        r_mask[1] <= '0;
      end
      if (clear_i) begin
        r_mask[w_new_shadow] <= '0;
        for (int r = 0; r < MAX_DIM; r++) r_mem[w_new_shadow][r] <= '0;
      end
    end
  end

  assign wr_err_o      = r_wr_err;
  assign swap_pend_o   = (r_state == S_PEND);
  assign swap_done_o   = r_swap_done;
  assign active_bank_o = r_active;
  assign shadow_full_o = w_full;
  assign rd_data_o     = r_rd_data;
  assign rd_valid_o    = r_rd_valid;

endmodule

// File: tb/tb_operands_buffer.sv
// Bench for operands_buffer: directed steps plus random traffic against a bank/mask model.
module tb_operands_buffer;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        wr_en_i;
  logic [31:0] wr_addr_i;
  logic [63:0] wr_data_i;
  logic [1:0]  wr_strb_i;
  logic        wr_err_o;
  logic        clear_i;
  logic        swap_i;
  logic        swap_pend_o;
  logic        swap_done_o;
  logic        active_bank_o;
  logic        shadow_full_o;
  logic        rd_en_i;
  logic [31:0] rd_addr_i;
  logic [63:0] rd_data_o;
  logic        rd_valid_o;

  operands_buffer dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_strb_i(wr_strb_i),
    .wr_err_o(wr_err_o), .clear_i(clear_i), .swap_i(swap_i), .swap_pend_o(swap_pend_o),
    .swap_done_o(swap_done_o), .active_bank_o(active_bank_o), .shadow_full_o(shadow_full_o),
    .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o)
  );

  always #5 clk = ~clk;

  // Reference model: two banks of two rows, a row-loaded flag per bank, active index.
  logic [63:0] m_bank [2][2];
  logic [1:0]  m_mask [2];
  int          m_act;
  bit          m_pend;
  logic [63:0] e_rdata;
  logic        e_valid, e_err, e_done;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("rd_valid", 64'(rd_valid_o), 64'(e_valid));
    chk("rd_data", rd_data_o, e_rdata);
    chk("wr_err", 64'(wr_err_o), 64'(e_err));
    chk("swap_done", 64'(swap_done_o), 64'(e_done));
    chk("active_bank", 64'(active_bank_o), 64'(m_act));
    chk("swap_pend", 64'(swap_pend_o), 64'(m_pend));
    chk("shadow_full", 64'(shadow_full_o), 64'(m_mask[1-m_act] == 2'b11));
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; wr_en_i = 1'b0; clear_i = 1'b0; swap_i = 1'b0; rd_en_i = 1'b0;
    @(posedge clk);
    for (int b = 0; b < 2; b++) begin
      m_mask[b] = 2'b00;
      for (int r = 0; r < 2; r++) m_bank[b][r] = '0;
    end
    m_act = 0; m_pend = 0; e_rdata = '0; e_valid = 0; e_err = 0; e_done = 0;
    #1 check_all();
    rst_ni = 1'b1;
  endtask

  task automatic cycle(input logic we, input logic [31:0] wa, input logic [63:0] wd,
                       input logic [1:0] ws, input logic clr, input logic sw,
                       input logic re, input logic [31:0] ra);
    bit full, do_swap;
    int sh;
    wr_en_i = we; wr_addr_i = wa; wr_data_i = wd; wr_strb_i = ws;
    clear_i = clr; swap_i = sw; rd_en_i = re; rd_addr_i = ra;
    @(posedge clk);
    sh   = 1 - m_act;
    full = (m_mask[sh] == 2'b11);
    e_valid = re;
    if (re) e_rdata = (ra < 2) ? m_bank[m_act][ra] : 64'd0;
    e_err   = we && (wa >= 2) && !clr;
    do_swap = full && (m_pend || sw);
    if (we && !clr && wa < 2) begin
      if (ws[0]) m_bank[sh][wa][31:0]  = wd[31:0];
      if (ws[1]) m_bank[sh][wa][63:32] = wd[63:32];
      if (ws != 2'b00) m_mask[sh][wa] = 1'b1;
    end
    if (do_swap) begin
      m_act = 1 - m_act;
      m_mask[1-m_act] = 2'b00;
      m_pend = 0;
    end else if (sw) begin
      m_pend = 1;
    end
    if (clr) begin
      m_mask[1-m_act] = 2'b00;
      m_bank[1-m_act][0] = '0;
      m_bank[1-m_act][1] = '0;
    end
    e_done = do_swap;
    #1 check_all();
  endtask

  task automatic idle();
    cycle(1'b0, 32'd0, 64'd0, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [63:0] d, input logic [1:0] s);
    cycle(1'b1, a, d, s, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic rd(input logic [31:0] a);
    cycle(1'b0, 32'd0, 64'd0, 2'b00, 1'b0, 1'b0, 1'b1, a);
  endtask

  task automatic swap();
    cycle(1'b0, 32'd0, 64'd0, 2'b00, 1'b0, 1'b1, 1'b0, 32'd0);
  endtask

  initial begin
    do_reset();
    do_reset();

    // Load shadow bank 1, read the still-empty active bank 0.
    wr(32'd0, 64'h1111_1111_2222_2222, 2'b11);
    wr(32'd1, 64'h3333_3333_4444_4444, 2'b11);
    chk("full_after_load", 64'(shadow_full_o), 64'd1);
    rd(32'd0);
    rd(32'd1);
    swap();
    chk("swap_active", 64'(active_bank_o), 64'd1);
    idle();
    rd(32'd1);
    chk("row1_after_swap", rd_data_o, 64'h3333_3333_4444_4444);
    rd(32'd0);

    // Strobed partial write into shadow bank 0.
    wr(32'd0, 64'h1111_1111_2222_2222, 2'b11);
    wr(32'd0, 64'hAAAA_AAAA_BBBB_BBBB, 2'b01);
    wr(32'd1, 64'h5555_5555_6666_6666, 2'b10);
    swap();
    rd(32'd0);
    chk("strobe_row0", rd_data_o, 64'h1111_1111_BBBB_BBBB);
    rd(32'd1);

    // Pending swap through a clear.
    wr(32'd0, 64'h0123_4567_89AB_CDEF, 2'b11);
    swap();
    chk("pend_set", 64'(swap_pend_o), 64'd1);
    cycle(1'b0, 32'd0, 64'd0, 2'b00, 1'b1, 1'b0, 1'b0, 32'd0);
    wr(32'd0, 64'hDEAD_BEEF_0000_0001, 2'b11);
    wr(32'd1, 64'hDEAD_BEEF_0000_0002, 2'b11);
    chk("pend_hold", 64'(swap_pend_o), 64'd1);
    idle();
    chk("pend_swap_done", 64'(swap_done_o), 64'd1);
    idle();
    rd(32'd1);

    // Out-of-range accesses.
    wr(32'd2, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11);
    chk("oob_wr_err", 64'(wr_err_o), 64'd1);
    rd(32'd5);
    chk("oob_rd_data", rd_data_o, 64'd0);

    // Read in the swap cycle sees the old active bank.
    wr(32'd0, 64'h7777_0000_7777_0000, 2'b11);
    wr(32'd1, 64'h8888_0000_8888_0000, 2'b11);
    cycle(1'b0, 32'd0, 64'd0, 2'b00, 1'b0, 1'b1, 1'b1, 32'd1);
    chk("rd_swap_old", rd_data_o, 64'hDEAD_BEEF_0000_0002);
    rd(32'd1);

    // Write together with clear is dropped without an error.
    cycle(1'b1, 32'd0, 64'h9999_9999_9999_9999, 2'b11, 1'b1, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 32'd7, 64'h9999_9999_9999_9999, 2'b11, 1'b1, 1'b0, 1'b0, 32'd0);
    wr(32'd1, 64'h1234_0000_0000_4321, 2'b11);
    chk("clr_drop_notfull", 64'(shadow_full_o), 64'd0);

    // Reset while a swap is pending.
    swap();
    do_reset();
    idle();
    idle();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      else
        cycle(1'($urandom_range(0, 2) != 0), 32'($urandom_range(0, 3)),
              {$urandom, $urandom}, 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 1)), 32'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
